// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one byte-level I2C master engine between two requesters. A requester
// wins the bus with a START operation. It then keeps the bus and may issue
// further byte operations, including repeated starts, until one of its
// operations completes with STOP or the transfer fails. On NACK or timeout the
// arbiter issues its own STOP before it frees the bus.
//
// Every output is registered. Outputs therefore reach their reset values only
// through the asynchronous register clear.
//
// Optional feature: define I2C_ARB_HOLD_TIMEOUT_EN to forcibly release an owner
// that stays idle in HOLD for HOLD_MAX cycles.
//
// Ports
//   clock, rst_n                 clock, asynchronous active-low reset
//   rqN_valid/start/stop/rw      requester N byte operation and its flags (N=0,1)
//   rqN_data[7:0]                byte to write, or address byte
//   rqN_accept                   one-cycle pulse: operation taken
//   rqN_ack/nack/to              one-cycle result pulses
//   rd_data[7:0]                 byte captured on the last acknowledged read
//   owner[1:0]                   one-hot grant, 00 when the bus is free
//   m_go/start/stop/rw, m_dataW  command to the master engine
//   m_ack/nack/to/busy, m_dataR  status and read data from the master engine
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 1000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       rq0_valid,
  input  logic       rq0_start,
  input  logic       rq0_stop,
  input  logic       rq0_rw,
  input  logic [7:0] rq0_data,
  output logic       rq0_accept,
  output logic       rq0_ack,
  output logic       rq0_nack,
  output logic       rq0_to,
  input  logic       rq1_valid,
  input  logic       rq1_start,
  input  logic       rq1_stop,
  input  logic       rq1_rw,
  input  logic [7:0] rq1_data,
  output logic       rq1_accept,
  output logic       rq1_ack,
  output logic       rq1_nack,
  output logic       rq1_to,
  output logic [7:0] rd_data,
  output logic [1:0] owner,
  output logic       m_go,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_rw,
  output logic [7:0] m_dataW,
  input  logic       m_ack,
  input  logic       m_nack,
  input  logic       m_to,
  input  logic       m_busy,
  input  logic [7:0] m_dataR
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, ABORT, DRAIN} state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       lastGrant_q, lastGrant_d;
  logic       opStart_q, opStart_d, opStop_q, opStop_d, opRw_q, opRw_d;
  logic [7:0] opData_q, opData_d;
  logic       mGo_q, mGo_d, mStart_q, mStart_d, mStop_q, mStop_d, mRw_q, mRw_d;
  logic [7:0] mDataW_q, mDataW_d;
  logic [7:0] rdData_q, rdData_d;
  logic [1:0] accept_q, accept_d, ack_q, ack_d, nack_q, nack_d, to_q, to_d;

  logic elig0, elig1, ownerValid, take, pick1;

`ifdef I2C_ARB_HOLD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_MAX - 1);
  logic [CntW-1:0] holdCnt_q, holdCnt_d;
`else
  logic unusedHoldMax;
  assign unusedHoldMax = (HOLD_MAX == 0);
`endif

  assign elig0      = rq0_valid & rq0_start;
  assign elig1      = rq1_valid & rq1_start;
  assign ownerValid = (owner_q[0] & rq0_valid) | (owner_q[1] & rq1_valid);

  // Next-state logic. The one-cycle pulses default to zero, and every held
  // register defaults to its current value.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    opStart_d   = opStart_q;
    opStop_d    = opStop_q;
    opRw_d      = opRw_q;
    opData_d    = opData_q;
    mGo_d       = 1'b0;
    mStart_d    = mStart_q;
    mStop_d     = mStop_q;
    mRw_d       = mRw_q;
    mDataW_d    = mDataW_q;
    rdData_d    = rdData_q;
    accept_d    = 2'b00;
    ack_d       = 2'b00;
    nack_d      = 2'b00;
    to_d        = 2'b00;
    take        = 1'b0;
    pick1       = 1'b0;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
    holdCnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          // When both requesters are eligible, the one not granted last wins.
          pick1    = elig1 & (~elig0 | ~lastGrant_q);
          owner_d  = pick1 ? 2'b10 : 2'b01;
          accept_d = owner_d;
          take     = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mGo_d    = 1'b1;
        mStart_d = opStart_q;
        mStop_d  = opStop_q;
        mRw_d    = opRw_q;
        mDataW_d = opData_q;
        state_d  = WAIT;
      end
      WAIT: begin
        // A failure beats a simultaneous ack, so no ack pulse is raised then.
        if (m_nack | m_to) begin
          if (m_nack) nack_d = owner_q;
          else        to_d   = owner_q;
          state_d = ABORT;
        end else if (m_ack) begin
          ack_d = owner_q;
          if (mRw_q) rdData_d = m_dataR;
          state_d = opStop_q ? DRAIN : HOLD;
        end
      end
      HOLD: begin
        // Only the owner's request is considered here. Its start flag is
        // passed through unchanged, so it can issue a repeated start.
        if (ownerValid) begin
          pick1    = owner_q[1];
          accept_d = owner_q;
          take     = 1'b1;
          state_d  = ISSUE;
        end
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
        else if (holdCnt_q == HoldLast) begin
          to_d    = owner_q;
          state_d = ABORT;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
`endif
      end
      ABORT: begin
        mGo_d    = 1'b1;
        mStart_d = 1'b0;
        mStop_d  = 1'b1;
        mRw_d    = 1'b0;
        mDataW_d = 8'h00;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (!m_busy) begin
          lastGrant_d = owner_q[1];
          owner_d     = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      opStart_d = pick1 ? rq1_start : rq0_start;
      opStop_d  = pick1 ? rq1_stop  : rq0_stop;
      opRw_d    = pick1 ? rq1_rw    : rq0_rw;
      opData_d  = pick1 ? rq1_data  : rq0_data;
    end
  end

  // Register bank. After reset, lastGrant points at requester 1 so that
  // requester 0 wins the first tie.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'b00;
      lastGrant_q <= 1'b1;
      opStart_q   <= 1'b0;
      opStop_q    <= 1'b0;
      opRw_q      <= 1'b0;
      opData_q    <= 8'h00;
      mGo_q       <= 1'b0;
      mStart_q    <= 1'b0;
      mStop_q     <= 1'b0;
      mRw_q       <= 1'b0;
      mDataW_q    <= 8'h00;
      rdData_q    <= 8'h00;
      accept_q    <= 2'b00;
      ack_q       <= 2'b00;
      nack_q      <= 2'b00;
      to_q        <= 2'b00;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
      holdCnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      opStart_q   <= opStart_d;
      opStop_q    <= opStop_d;
      opRw_q      <= opRw_d;
      opData_q    <= opData_d;
      mGo_q       <= mGo_d;
      mStart_q    <= mStart_d;
      mStop_q     <= mStop_d;
      mRw_q       <= mRw_d;
      mDataW_q    <= mDataW_d;
      rdData_q    <= rdData_d;
      accept_q    <= accept_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      to_q        <= to_d;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
      holdCnt_q   <= holdCnt_d;
`endif
    end
  end

  assign owner      = owner_q;
  assign rd_data    = rdData_q;
  assign m_go       = mGo_q;
  assign m_start    = mStart_q;
  assign m_stop     = mStop_q;
  assign m_rw       = mRw_q;
  assign m_dataW    = mDataW_q;
  assign rq0_accept = accept_q[0];
  assign rq1_accept = accept_q[1];
  assign rq0_ack    = ack_q[0];
  assign rq1_ack    = ack_q[1];
  assign rq0_nack   = nack_q[0];
  assign rq1_nack   = nack_q[1];
  assign rq0_to     = to_q[0];
  assign rq1_to     = to_q[1];

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 1000, max clock cycles an owner may idle in HOLD before forced release (used only under REQ-030).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rqN_valid  input  1  (N=0,1) requester N presents one byte operation.
REQ-005 rqN_start, rqN_stop, rqN_rw  input  1 each  operation flags as consumed by the I2C master engine.
REQ-006 rqN_data  input  8  byte to write or address byte.
REQ-007 rqN_accept  output  1  one-cycle pulse: operation taken.
REQ-008 rqN_ack, rqN_nack, rqN_to  output  1 each  one-cycle result pulses to requester N.
REQ-009 rd_data  output  8  last m_dataR captured on ACK of a read; shared.
REQ-010 owner  output  2  one-hot current grant; 00 when bus free.
REQ-011 m_go, m_start, m_stop, m_rw  output  1 each; m_dataW  output  8  drive to I2C master engine.
REQ-012 m_ack, m_nack, m_to, m_busy  input  1 each; m_dataR  input  8  from I2C master engine.

Function
REQ-013 States: IDLE, ISSUE, WAIT, HOLD, ABORT, DRAIN.
REQ-014 IDLE: only requests with rqN_valid=1 and rqN_start=1 are eligible; requests without start are not accepted and stay pending.
REQ-015 IDLE arbitration: single eligible requester wins; both eligible -> requester not granted last wins; after reset requester 0 wins first tie.
REQ-016 On grant: owner set, rqN_accept pulses same cycle, operation latched, state -> ISSUE.
REQ-017 ISSUE: m_go=1 for exactly one cycle with latched m_start/m_stop/m_rw/m_dataW; -> WAIT; go therefore asserts 1 cycle after acceptance.
REQ-018 m_start/m_stop/m_rw/m_dataW hold their values from ISSUE until the next ISSUE or ABORT.
REQ-019 WAIT, m_ack=1: rqN_ack pulse to owner; if m_rw=1 rd_data <= m_dataR same edge; latched stop=1 -> DRAIN, else -> HOLD.
REQ-020 WAIT, m_nack=1: rqN_nack pulse to owner, -> ABORT; m_to=1: rqN_to pulse, -> ABORT; simultaneous ack with nack/to: nack/to wins, no ack pulse.
REQ-021 HOLD: only owner's rqN_valid is accepted (start flag ignored, repeated start passed through); other requester never accepted until bus free.
REQ-022 ABORT: one-cycle m_go with m_start=0, m_stop=1, m_dataW=8'h00, m_rw=0; -> DRAIN; no further result pulse for the abort stop.
REQ-023 DRAIN: wait for m_busy=0; then owner <= 00, last-grant pointer <= released owner, -> IDLE.
REQ-024 Engine result inputs arriving outside WAIT are ignored.
REQ-025 Non-owner valid during ISSUE/WAIT/HOLD/ABORT/DRAIN: rqN_accept stays 0; request remains pending.
REQ-026 At most one of rqN_accept, rqN_ack, rqN_nack, rqN_to asserted per requester per cycle; all pulses exactly one cycle.

Reset
REQ-027 rst_n=0 forces immediately: state IDLE, owner 00, all m_* outputs 0, m_dataW 8'h00, rd_data 8'h00, all accept/result pulses 0, last-grant pointer = requester 1.
REQ-028 Reset mid-transaction abandons the transfer without issuing stop; first post-reset grant follows REQ-015.
REQ-029 No output depends combinationally on rst_n other than via the asynchronous register clear.

Configuration
REQ-030 Macro I2C_ARB_HOLD_TIMEOUT_EN defined: cycle counter runs in HOLD, cleared on entry; reaching HOLD_MAX with no owner valid -> rqN_to pulse to owner, -> ABORT.
REQ-031 Macro undefined: no counter; owner may remain in HOLD indefinitely; HOLD_MAX unused.

Verification
REQ-032 rq0 valid,start,data=8'hA0,rw=0; engine ack 5 cycles after go -> rq0_accept at cycle 0, m_go at cycle 1, rq0_ack once, state HOLD, owner=01.
REQ-033 rq0 and rq1 both valid with start from reset -> rq0 granted; after rq0 stop-op acked and m_busy=0, pending rq1 granted next IDLE cycle, owner=10.
REQ-034 rq1 owns in HOLD, rq0 valid with start for 50 cycles -> rq0_accept stays 0; rq1 read op rw=1 acked with m_dataR=8'h5C -> rd_data=8'h5C, rq1_ack pulse.
REQ-035 Owner write gets m_nack -> rq_nack pulse, next cycle-pair m_go with m_stop=1, m_dataW=8'h00; bus freed after m_busy=0.
REQ-036 m_ack and m_to same cycle in WAIT -> only rq_to pulse, ABORT entered; rst_n low in WAIT -> all outputs 0 immediately, owner 00.
REQ-037 With I2C_ARB_HOLD_TIMEOUT_EN, HOLD_MAX=20, owner idle in HOLD -> rq_to at cycle 20, stop issued; without macro, no stop after 1000 cycles.
